// File: rtl/dmem_pkg.sv
// Shared types and encodings for the data-memory access controller.
package dmem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   localparam int DEF_TIMEOUT = 255;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic [1:0]  size;
      logic        uns;
   } req_t;

   // Illegal size or an address not naturally aligned to the access size.
   function automatic logic bad_access(input logic [1:0] size, input logic [1:0] a);
      case (size)
         SZ_BYTE: bad_access = 1'b0;
         SZ_HALF: bad_access = a[0];
         SZ_WORD: bad_access = (a != 2'b00);
         default: bad_access = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/dmem_access_ctrl_load_aligner.sv
// Combinational load aligner: picks the addressed lane(s) and extends to 32 bits.
module load_aligner
   import dmem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [1:0]  size,
   input  logic        uns,
   output logic [31:0] result
);

   logic [3:0][7:0] lanes;
   logic [7:0]      byte_v;
   logic [15:0]     half_v;

   assign lanes  = rdata;
   assign byte_v = lanes[addr];
   assign half_v = addr[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      result = '0;
      case (size)
         SZ_BYTE: result = {{24{~uns & byte_v[7]}}, byte_v};
         SZ_HALF: result = {{16{~uns & half_v[15]}}, half_v};
         SZ_WORD: result = rdata;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: one outstanding load/store on a valid/ready bus,
// with alignment checks, load extension and a bus timeout.
module dmem_access_ctrl
   import dmem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wmask,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   output logic        req_ready,
   output logic        stall,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_valid,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_ready,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   // Last counted cycle before abort; a zero or one budget aborts after one cycle.
   localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES > 1) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

   state_t      state;
   req_t        r;
   logic [31:0] cnt;
   logic [31:0] aligned;
   logic        timed_out;

   load_aligner u_align (
      .rdata  (mem_rdata),
      .addr   (r.addr[1:0]),
      .size   (r.size),
      .uns    (r.uns),
      .result (aligned)
   );

   assign timed_out = (cnt >= TO_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         r          <= '0;
         cnt        <= '0;
         req_ready  <= 1'b1;
         stall      <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         mem_valid  <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wmask  <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  r         <= '{we: req_we, addr: req_addr, wdata: req_wdata,
                                 wmask: req_wmask, size: req_size, uns: req_unsigned};
                  cnt       <= '0;
                  req_ready <= 1'b0;
                  if (bad_access(req_size, req_addr[1:0])) begin
                     state      <= ST_RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else if (req_we && req_wmask == 4'b0000) begin
                     // Empty store: nothing to write, complete without touching the bus.
                     state      <= ST_RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b0;
                     resp_rdata <= '0;
                  end else begin
                     state     <= ST_ISSUE;
                     stall     <= 1'b1;
                     mem_valid <= 1'b1;
                     mem_we    <= req_we;
                     mem_addr  <= {req_addr[31:2], 2'b00};
                     mem_wdata <= req_wdata;
                     mem_wmask <= req_we ? req_wmask : 4'b0000;
                  end
               end
            end

            ST_ISSUE: begin
               if (mem_ready || timed_out) begin
                  mem_valid <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_wmask <= '0;
               end
               if (mem_ready && !r.we) begin
                  state <= ST_WAIT;
                  cnt   <= cnt + 32'd1;
               end else if (mem_ready || timed_out) begin
                  state      <= ST_RESP;
                  stall      <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= !mem_ready;
                  resp_rdata <= '0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end

            ST_WAIT: begin
               if (mem_rvalid || timed_out) begin
                  state      <= ST_RESP;
                  stall      <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= !mem_rvalid;
                  resp_rdata <= mem_rvalid ? aligned : 32'd0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end

            ST_RESP: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/dmem_access_ctrl.md
DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: max cycles in ISSUE+WAIT before abort.
REQ-002 SHALL have ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  access request from store/load stage
- req_we  in  1  1=store, 0=load
- req_addr  in  32  byte address
- req_wdata  in  32  replicated store data
- req_wmask  in  4  byte lanes
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  zero-extend loads
- req_ready  out  1  request accepted this cycle
- stall  out  1  freeze upstream pipeline
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  aligned, extended load data
- resp_err  out  1  misaligned/illegal/timeout
- mem_valid  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  32  word-aligned address
- mem_wdata  out  32  write data
- mem_wmask  out  4  write lanes
- mem_ready  in  1  bus accepts request
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word

Function
REQ-003 SHALL implement FSM IDLE, ISSUE, WAIT, RESP.
REQ-004 SHALL drive req_ready=1 only in IDLE; req_valid&req_ready latches all req_* fields.
REQ-005 SHALL on acceptance go to RESP with error if size=11, half with addr[0]=1, or word with addr[1:0]!=00; no bus transaction.
REQ-006 SHALL on acceptance of a store with wmask=0000 go to RESP, err=0, no bus transaction.
REQ-007 SHALL otherwise go to ISSUE, driving mem_valid=1, mem_addr={addr[31:2],00}, mem_we, mem_wdata, mem_wmask (0000 for loads), all stable until mem_ready.
REQ-008 SHALL on mem_ready in ISSUE go to RESP (store) or WAIT (load).
REQ-009 SHALL ignore mem_rvalid outside WAIT; in WAIT on mem_rvalid capture aligned data and go to RESP.
REQ-010 SHALL align loads: byte selects lane addr[1:0], half selects lane addr[1], word passes; sign-extend unless req_unsigned.
REQ-011 SHALL count cycles in ISSUE+WAIT; reaching TIMEOUT_CYCLES goes to RESP with err=1, mem_valid dropped.
REQ-012 SHALL assert resp_valid exactly one cycle in RESP, then IDLE; resp_rdata=0 for stores and errors; resp_rdata/resp_err held until next RESP.
REQ-013 SHALL assert stall=1 in ISSUE and WAIT only.
REQ-014 SHALL give minimum latency acceptance->resp_valid of 2 cycles (store, mem_ready immediate) and 3 cycles (load, mem_rvalid one cycle after handshake).

Reset
REQ-015 SHALL on rst: state IDLE, counter 0, req_ready=1, stall=0, resp_valid=0, resp_rdata=0, resp_err=0, mem_valid=0, mem_we=0, mem_wmask=0.
REQ-016 SHALL abort any in-flight access on rst with no response; later mem_rvalid ignored.

Structure
REQ-017 SHALL place state enum, size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and default timeout in package dmem_pkg.
REQ-018 SHALL use one combinational sub-module load_aligner (rdata, addr[1:0], size, unsigned -> 32-bit result).

Verification
REQ-019 Store byte addr 0x103, wmask 1000, mem_ready immediate -> mem_addr 0x100, mem_wmask 1000, resp_valid 2 cycles after accept, err=0.
REQ-020 Load byte addr 0x101 signed, mem_rdata 0x0000_8000 -> resp_rdata 0xFFFF_FF80; unsigned -> 0x0000_0080.
REQ-021 Load half addr 0x102, mem_rdata 0x8001_1234 -> 0xFFFF_8001 signed; word addr 0x102 -> resp_err=1, mem_valid never asserted.
REQ-022 mem_ready held 0, TIMEOUT_CYCLES=4 -> resp_err=1 after 4 ISSUE cycles, stall high exactly those cycles.
REQ-023 rst asserted in WAIT, mem_rvalid pulsed after -> no resp_valid, req_ready=1 cycle after reset.
